// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared state encoding and size defaults for the RAM arbiter
package ram_ctrl_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACCESS = ST_ACCESS,
        S_DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = 1'b0;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ptr;
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arb2_ctrl.sv
// rtl/ram_arb2_ctrl.sv - two-client round-robin sequencer for a shared single-port RAM
module ram_arb2_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] D0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] D1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO
);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          gnt_valid;
    logic          gnt_id;

    rr_arb2 u_arb (
        .req       ({REQ1, REQ0}),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        a_d     = a_q;
        d_d     = d_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    we_d    = gnt_id ? WE1 : WE0;
                    a_d     = gnt_id ? A1 : A0;
                    d_d     = gnt_id ? D1 : D0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // writes echo their own data so every ACK carries meaningful RDATA
                rdata_d = we_q ? d_q : RAM_DO;
                state_d = S_DONE;
            end
            S_DONE: begin
                ptr_d   = ~id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            d_q     <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            a_q     <= a_d;
            d_q     <= d_d;
            rdata_q <= rdata_d;
        end
    end

    // RST masks the strobe so a write interrupted by reset never lands in the RAM
    assign RAM_WE = (state_q == S_ACCESS) && we_q && !RST;
    assign RAM_A  = a_q;
    assign RAM_DI = d_q;
    assign ACK0   = (state_q == S_DONE) && !id_q;
    assign ACK1   = (state_q == S_DONE) && id_q;
    assign BUSY   = (state_q != S_IDLE);
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_ram_arb2_ctrl.sv
// tb/tb_ram_arb2_ctrl.sv - directed self-checking bench for ram_arb2_ctrl with a RAM model
module tb_ram_arb2_ctrl;

    localparam int AW = 5;
    localparam int DW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, WE0, REQ1, WE1;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] D0, D1;
    logic          ACK0, ACK1, BUSY, RAM_WE;
    logic [DW-1:0] RDATA, RAM_DI, RAM_DO;
    logic [AW-1:0] RAM_A;

    logic [DW-1:0] mem [0:31];

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ram_arb2_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ0   (REQ0),
        .WE0    (WE0),
        .A0     (A0),
        .D0     (D0),
        .REQ1   (REQ1),
        .WE1    (WE1),
        .A1     (A1),
        .D1     (D1),
        .ACK0   (ACK0),
        .ACK1   (ACK1),
        .RDATA  (RDATA),
        .BUSY   (BUSY),
        .RAM_WE (RAM_WE),
        .RAM_A  (RAM_A),
        .RAM_DI (RAM_DI),
        .RAM_DO (RAM_DO)
    );

    assign RAM_DO = mem[RAM_A];

    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_A] <= RAM_DI;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop_all;
        REQ0 = 1'b0; WE0 = 1'b0; A0 = '0; D0 = '0;
        REQ1 = 1'b0; WE1 = 1'b0; A1 = '0; D1 = '0;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        tick;
        tick;
        RST = 1'b0;
    endtask

    // single transaction from an idle controller: exact 2-cycle latency expected
    task automatic txn(input string tag, input bit cl, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_rd);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        if (cl) begin REQ1 = 1'b1; WE1 = we; A1 = a; D1 = d; end
        else    begin REQ0 = 1'b1; WE0 = we; A0 = a; D0 = d; end
        while (!got && n < 8) begin
            tick;
            n++;
            got = cl ? ACK1 : ACK0;
        end
        chk({tag, "_ack"}, got, 1);
        chk({tag, "_latency"}, n, 2);
        chk({tag, "_rdata"}, RDATA, exp_rd);
        chk({tag, "_other_ack"}, cl ? ACK0 : ACK1, 0);
        drop_all;
        tick;
        chk({tag, "_idle"}, {BUSY, ACK0, ACK1}, 3'b000);
        chk({tag, "_rdata_hold"}, RDATA, exp_rd);
    endtask

    initial begin
        int  gap;
        bit  exp_id;
        bit  got;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i) ^ 4'h5;
        drop_all;

        // reset values
        do_reset;
        chk("rst_busy", BUSY, 0);
        chk("rst_acks", {ACK0, ACK1}, 2'b00);
        chk("rst_rdata", RDATA, 0);
        chk("rst_ram_we", RAM_WE, 0);
        chk("rst_ram_a", RAM_A, 0);
        chk("rst_ram_di", RAM_DI, 0);

        // reset during the ACCESS cycle of a write to A=9
        REQ0 = 1'b1; WE0 = 1'b1; A0 = 5'd9; D0 = 4'h3;
        tick;
        chk("mid_busy", BUSY, 1);
        chk("mid_ram_we", RAM_WE, 1);
        chk("mid_ram_a", RAM_A, 9);
        RST = 1'b1;
        tick;
        drop_all;
        chk("mid_rst_ram_we", RAM_WE, 0);
        chk("mid_rst_acks", {ACK0, ACK1}, 2'b00);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_rdata", RDATA, 0);
        tick;
        RST = 1'b0;
        tick;
        chk("mid_rst_no_write", mem[9], 4'hC);
        chk("mid_rst_still_idle", BUSY, 0);

        // single write then read
        txn("wr5", 1'b0, 1'b1, 5'd5, 4'hA, 4'hA);
        chk("wr5_mem", mem[5], 4'hA);
        txn("rd5", 1'b0, 1'b0, 5'd5, 4'h0, 4'hA);

        // contention straight after reset: client 0 wins, client 1 three cycles later
        do_reset;
        REQ0 = 1'b1; WE0 = 1'b1; A0 = 5'd1; D0 = 4'h3;
        REQ1 = 1'b1; WE1 = 1'b1; A1 = 5'd2; D1 = 4'hC;
        tick;
        tick;
        chk("cont_first_ack", {ACK1, ACK0}, 2'b01);
        chk("cont_first_rdata", RDATA, 4'h3);
        REQ0 = 1'b0;
        tick;
        tick;
        chk("cont_gap_quiet", {ACK1, ACK0}, 2'b00);
        tick;
        chk("cont_second_ack", {ACK1, ACK0}, 2'b10);
        chk("cont_second_rdata", RDATA, 4'hC);
        drop_all;
        tick;
        chk("cont_mem1", mem[1], 4'h3);
        chk("cont_mem2", mem[2], 4'hC);

        // fairness: both clients reading continuously, 12 ACKs
        REQ0 = 1'b1; WE0 = 1'b0; A0 = 5'd1;
        REQ1 = 1'b1; WE1 = 1'b0; A1 = 5'd2;
        exp_id = 1'b0;
        for (int k = 0; k < 12; k++) begin
            gap = 0;
            got = 1'b0;
            while (!got && gap < 10) begin
                tick;
                gap++;
                got = ACK0 | ACK1;
            end
            chk("fair_ack_seen", got, 1);
            chk("fair_order", {ACK1, ACK0}, exp_id ? 2'b10 : 2'b01);
            chk("fair_gap", gap, (k == 0) ? 2 : 3);
            chk("fair_rdata", RDATA, exp_id ? 4'hC : 4'h3);
            exp_id = ~exp_id;
        end
        drop_all;
        tick;
        chk("fair_idle", BUSY, 0);

        // wrap-around address
        txn("wr31", 1'b0, 1'b1, 5'd31, 4'hF, 4'hF);
        txn("rd31", 1'b0, 1'b0, 5'd31, 4'h0, 4'hF);
        txn("rd0", 1'b0, 1'b0, 5'd0, 4'h0, 4'h5);

        // read-after-write across clients
        txn("c1_wr7", 1'b1, 1'b1, 5'd7, 4'h6, 4'h6);
        txn("c0_rd7", 1'b0, 1'b0, 5'd7, 4'h0, 4'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arb2_ctrl.md
Name: ram_arb2_ctrl

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32x4 single-port RAM (synchronous write, combinational read).
- Accepts read/write transactions from two clients over a REQ/ACK handshake and serialises them onto the RAM port.
- Returns registered read data and a one-cycle ACK to the served client.
- Sits between the RAM and its two producers/consumers: the function/adder write path and the readback/display path.

Parameters:
- AW, 5, RAM address width (32 words).
- DW, 4, RAM data width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ0  input  1  client 0 request; held high until ACK0 is seen.
- WE0  input  1  client 0: 1 = write, 0 = read; stable while REQ0 is high.
- A0  input  AW  client 0 address.
- D0  input  DW  client 0 write data.
- REQ1, WE1, A1, D1  input  1/1/AW/DW  client 1 equivalents.
- ACK0  output  1  one-cycle pulse: client 0 transaction complete.
- ACK1  output  1  one-cycle pulse: client 1 transaction complete.
- RDATA  output  DW  data of the completed transaction; valid while ACKx is high.
- BUSY  output  1  high in any state other than IDLE.
- RAM_WE  output  1  RAM write enable.
- RAM_A  output  AW  RAM address.
- RAM_DI  output  DW  RAM write data.
- RAM_DO  input  DW  RAM combinational read data.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE, priority pointer PTR=0 (client 0 favoured), ACK0=ACK1=0, RDATA=0, BUSY=0, RAM_WE=0, RAM_A=0, RAM_DI=0, latched transaction registers cleared.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ high: grant that client, regardless of PTR.
  - Both REQ high: grant client PTR.
  - On grant: latch id, WE, A, D into internal registers; go to ACCESS.
- ACCESS (one cycle):
  - RAM_A = latched A. RAM_DI = latched D. RAM_WE = latched WE (decoded from state, so it is high only in this cycle).
  - At the clock edge: RDATA <= latched WE ? latched D : RAM_DO. A write returns its written data.
  - Go to DONE.
- DONE (one cycle):
  - ACK of the latched id is high; the other ACK stays 0.
  - At the edge: PTR <= ~latched id, so the other client is favoured next. Go to IDLE.
- Outside ACCESS: RAM_WE=0. RAM_A and RAM_DI hold their latched values (no glitching).
- Latency: REQ sampled high at edge k (in IDLE) -> ACK high during cycle k+2. Peak throughput is one transaction per 3 cycles.
- RDATA holds its value until the next ACCESS edge.
- Handshake rules:
  - A client keeps REQ/WE/A/D stable from REQ rise until it samples its ACK high.
  - The client drops REQ at the edge ending ACK, or raises it again for a back-to-back transaction.
  - The controller re-samples REQ in IDLE only, so a dropped REQ is never double-served.
- Fairness: with both clients continuously requesting, grants strictly alternate 0,1,0,1… No client waits more than one other transaction (≤ 5 cycles from REQ to the start of ACCESS).
- Wrap-around: AW=5, so addresses 0..31 are all valid. No range check.
- Simultaneous events:
  - A new REQ arriving during ACCESS/DONE is held off until IDLE.
  - Both REQ rising in the same cycle are resolved by PTR.
- Reset mid-operation: at the reset edge go to IDLE and drop RAM_WE and both ACKs. A write is never partially issued: it completes only if reset is low at the ACCESS edge.

Decomposition:
- Package ram_ctrl_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2.
  - AW/DW defaults.
- One sub-module, rr_arb2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], ptr.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Reset: assert RST for 2 cycles during ACCESS of a write -> RAM_WE=0 and ACK0=ACK1=0 from the next cycle; BUSY=0, RDATA=0.
- Single write then read: REQ0 write A=5, D=4'hA -> ACK0 2 cycles after sampling, RDATA=4'hA. Then REQ0 read A=5 -> RDATA=4'hA with ACK0.
- Contention: REQ0 (write A=1,D=3) and REQ1 (write A=2,D=C) rise together after reset -> client 0 acked first. Client 1 acked 3 cycles later. RAM[1]=3, RAM[2]=C.
- Fairness: both REQs held continuously for 12 transactions -> ACK order strictly alternates; gap between consecutive ACKs is 3 cycles.
- Wrap-around address: write A=31, D=F, then read A=31 and A=0 -> F and the prior A=0 contents; no aliasing.
- Read-after-write across clients: client 1 writes A=7, D=6; client 0 then reads A=7 -> RDATA=6 with ACK0.
